regfile_responder: RTL and testbench

- Responder side of the register-file access interface: a 2^ADDR_BITS x WIDTH register file with a valid/ready request port and a valid/ready response port.
- Executes one command per accepted request: optional write plus two reads, with register 0 hardwired to zero.
- Sits behind any initiator (test sequencer, datapath controller), so the register file can be exercised without a raw Clk-pulsed interface.
- Includes a post-reset clear sequencer so the array maps onto RAM without a parallel reset.

---
 rtl/regfile_responder.sv | 146 ++++++++++++++
 tb/tb_regfile_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_responder.sv
// Register-file responder: valid/ready request and response ports around a 2^ADDR_BITS x WIDTH array.
// After reset, a clear sequencer zeroes registers 1..N-1 one per cycle so the array needs no parallel reset.
module regfile_responder #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqWrite,
  input  logic [ADDR_BITS-1:0] ReqWriteRegister,
  input  logic [WIDTH-1:0]     ReqWriteData,
  input  logic [ADDR_BITS-1:0] ReqReadRegister1,
  input  logic [ADDR_BITS-1:0] ReqReadRegister2,
  output logic                 RespValid,
  input  logic                 RespReady,
  output logic [WIDTH-1:0]     RespReadData1,
  output logic [WIDTH-1:0]     RespReadData2,
  output logic [15:0]          WriteCount
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ZERO_IDX = ADDR_BITS'(0);
  localparam logic [ADDR_BITS-1:0] ONE_IDX  = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] LAST_IDX = {ADDR_BITS{1'b1}};

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   clear_idx_q, clear_idx_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]       rd1_q, rd1_d;
  logic [WIDTH-1:0]       rd2_q, rd2_d;
  logic [15:0]            wcount_q, wcount_d;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic [WIDTH-1:0]       mem_wdata;
  logic [WIDTH-1:0]       mem_rd1, mem_rd2;

  logic                   accept;
  logic                   wr_en;

  assign ReqReady      = (state_q == ST_RUN) && (!resp_valid_q || RespReady);
  assign accept        = ReqValid && ReqReady;
  assign wr_en         = ReqWrite && (ReqWriteRegister != ZERO_IDX);
  assign mem_rd1       = mem[ReqReadRegister1];
  assign mem_rd2       = mem[ReqReadRegister2];

  assign RespValid     = resp_valid_q;
  assign RespReadData1 = rd1_q;
  assign RespReadData2 = rd2_q;
  assign WriteCount    = wcount_q;

  // Next-state, array write port and response capture
  always_comb begin
    state_d      = state_q;
    clear_idx_d  = clear_idx_q;
    resp_valid_d = resp_valid_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    wcount_d     = wcount_q;
    mem_we       = 1'b0;
    mem_waddr    = clear_idx_q;
    mem_wdata    = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we      = 1'b1;
        clear_idx_d = clear_idx_q + ONE_IDX;
        if (clear_idx_q == LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (wr_en) begin
            mem_we    = 1'b1;
            mem_waddr = ReqWriteRegister;
            mem_wdata = ReqWriteData;
            if (wcount_q != 16'hFFFF) begin
              wcount_d = wcount_q + 16'd1;
            end else begin
              wcount_d = wcount_q;
            end
          end else begin
            mem_we = 1'b0;
          end
          // Write-first: a read of the address being written sees the new data
          if (ReqReadRegister1 == ZERO_IDX) begin
            rd1_d = '0;
          end else if (wr_en && (ReqReadRegister1 == ReqWriteRegister)) begin
            rd1_d = ReqWriteData;
          end else begin
            rd1_d = mem_rd1;
          end
          if (ReqReadRegister2 == ZERO_IDX) begin
            rd2_d = '0;
          end else if (wr_en && (ReqReadRegister2 == ReqWriteRegister)) begin
            rd2_d = ReqWriteData;
          end else begin
            rd2_d = mem_rd2;
          end
          resp_valid_d = 1'b1;
        end else if (resp_valid_q && RespReady) begin
          resp_valid_d = 1'b0;
        end else begin
          resp_valid_d = resp_valid_q;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Control and response registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_CLEAR;
      clear_idx_q  <= ONE_IDX;
      resp_valid_q <= 1'b0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      wcount_q     <= 16'd0;
    end else begin
      state_q      <= state_d;
      clear_idx_q  <= clear_idx_d;
      resp_valid_q <= resp_valid_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      wcount_q     <= wcount_d;
    end
  end

  // Register array, single write port, no reset so it can map onto RAM
  always_ff @(posedge Clk) begin
    if (!Reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_regfile_responder.sv
// Self-checking bench for regfile_responder: directed table, backpressure/reset sequences,
// and randomized traffic against an array-based reference model.
module tb_regfile_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [4:0]  ReqWriteRegister;
  logic [31:0] ReqWriteData;
  logic [4:0]  ReqReadRegister1;
  logic [4:0]  ReqReadRegister2;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] RespReadData1;
  logic [31:0] RespReadData2;
  logic [15:0] WriteCount;

  int tests = 0;
  int fails = 0;

  logic [31:0] model_mem [32];
  int          model_wc;

  typedef struct {
    string       name;
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [15:0] ewc;
  } vec_t;

  vec_t vecs [8];

  regfile_responder #(.WIDTH(32), .ADDR_BITS(5)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqWriteRegister(ReqWriteRegister), .ReqWriteData(ReqWriteData),
    .ReqReadRegister1(ReqReadRegister1), .ReqReadRegister2(ReqReadRegister2),
    .RespValid(RespValid), .RespReady(RespReady),
    .RespReadData1(RespReadData1), .RespReadData2(RespReadData2),
    .WriteCount(WriteCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
    model_wc = 0;
  endtask

  // Reference semantics: write (nonzero target only), then both reads; r0 reads as zero.
  task automatic model_apply(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                             input logic [4:0] r1, input logic [4:0] r2,
                             output logic [31:0] e1, output logic [31:0] e2);
    if (w && wa != 5'd0) begin
      model_mem[wa] = wd;
      if (model_wc < 65535) model_wc++;
    end
    e1 = (r1 == 5'd0) ? 32'd0 : model_mem[r1];
    e2 = (r2 == 5'd0) ? 32'd0 : model_mem[r2];
  endtask

  task automatic set_cmd(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
    ReqWrite = w; ReqWriteRegister = wa; ReqWriteData = wd;
    ReqReadRegister1 = r1; ReqReadRegister2 = r2;
  endtask

  task automatic do_cmd(input string nm, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] e1, input logic [31:0] e2, input logic [15:0] ewc);
    logic [31:0] m1, m2;
    set_cmd(w, wa, wd, r1, r2);
    ReqValid = 1'b1; RespReady = 1'b1;
    #1;
    chk({nm, ".ready"}, {31'd0, ReqReady}, 32'd1);
    step();
    ReqValid = 1'b0;
    model_apply(w, wa, wd, r1, r2, m1, m2);
    chk({nm, ".valid"}, {31'd0, RespValid}, 32'd1);
    chk({nm, ".rd1"}, RespReadData1, e1);
    chk({nm, ".rd2"}, RespReadData2, e2);
    chk({nm, ".wcount"}, {16'd0, WriteCount}, {16'd0, ewc});
  endtask

  // Counts cycles with ReqReady low after reset release; bounded so a stuck DUT cannot hang.
  task automatic wait_clear(input string nm);
    int cnt = 0;
    while (!ReqReady && cnt < 40) begin
      cnt++;
      step();
    end
    chk({nm, ".clear_cycles"}, cnt, 32'd31);
  endtask

  initial begin
    logic        exp_valid;
    logic [31:0] exp_d1, exp_d2;
    logic [31:0] t1, t2;
    logic        exp_ready;

    vecs[0] = '{"wr42_r2",   1'b1, 5'd2,  32'd42,        5'd2,  5'd2,  32'd42,        32'd42, 16'd1};
    vecs[1] = '{"wr15_r2",   1'b1, 5'd2,  32'd15,        5'd2,  5'd2,  32'd15,        32'd15, 16'd2};
    vecs[2] = '{"nowr_r4",   1'b0, 5'd4,  32'd22,        5'd4,  5'd4,  32'd0,         32'd0,  16'd2};
    vecs[3] = '{"wr55_r9",   1'b1, 5'd4,  32'd55,        5'd9,  5'd9,  32'd0,         32'd0,  16'd3};
    vecs[4] = '{"rd_r4_r9",  1'b0, 5'd0,  32'd0,         5'd4,  5'd9,  32'd55,        32'd0,  16'd3};
    vecs[5] = '{"wr82_r0",   1'b1, 5'd0,  32'd82,        5'd0,  5'd0,  32'd0,         32'd0,  16'd3};
    vecs[6] = '{"wr82_r7",   1'b1, 5'd7,  32'd82,        5'd7,  5'd7,  32'd82,        32'd82, 16'd4};
    vecs[7] = '{"wr_r31",    1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd30, 32'hFFFF_FFFF, 32'd0,  16'd5};

    Reset = 1'b1; ReqValid = 1'b1; RespReady = 1'b1;
    set_cmd(1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
    model_reset();
    step();
    step();
    chk("reset.valid", {31'd0, RespValid}, 32'd0);
    chk("reset.wcount", {16'd0, WriteCount}, 32'd0);
    chk("reset.ready", {31'd0, ReqReady}, 32'd0);
    chk("reset.rd1", RespReadData1, 32'd0);
    Reset = 1'b0;
    #1;
    wait_clear("init");
    step();
    ReqValid = 1'b0;
    chk("first.valid", {31'd0, RespValid}, 32'd1);
    chk("first.rd1", RespReadData1, 32'd0);
    chk("first.rd2", RespReadData2, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_cmd(vecs[i].name, vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].r2,
             vecs[i].e1, vecs[i].e2, vecs[i].ewc);
    end

    // Backpressure: response held stable, second command stalled until RespReady rises.
    step();
    chk("bp.idle", {31'd0, RespValid}, 32'd0);
    do_cmd("bp.first", 1'b1, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'd6);
    RespReady = 1'b0; ReqValid = 1'b1;
    set_cmd(1'b1, 5'd5, 32'h1234_5678, 5'd3, 5'd5);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp.stall_ready", {31'd0, ReqReady}, 32'd0);
      step();
      chk("bp.hold_valid", {31'd0, RespValid}, 32'd1);
      chk("bp.hold_rd1", RespReadData1, 32'hDEAD_BEEF);
      chk("bp.hold_rd2", RespReadData2, 32'hDEAD_BEEF);
      chk("bp.hold_wcount", {16'd0, WriteCount}, 32'd6);
    end
    RespReady = 1'b1;
    #1;
    chk("bp.release_ready", {31'd0, ReqReady}, 32'd1);
    step();
    ReqValid = 1'b0;
    model_apply(1'b1, 5'd5, 32'h1234_5678, 5'd3, 5'd5, t1, t2);
    chk("bp.second_valid", {31'd0, RespValid}, 32'd1);
    chk("bp.second_rd1", RespReadData1, 32'hDEAD_BEEF);
    chk("bp.second_rd2", RespReadData2, 32'h1234_5678);
    chk("bp.second_wcount", {16'd0, WriteCount}, 32'd7);

    // Randomized traffic with random backpressure against the reference model.
    step();
    chk("rnd.idle", {31'd0, RespValid}, 32'd0);
    exp_valid = 1'b0; exp_d1 = 32'd0; exp_d2 = 32'd0;
    for (int c = 0; c < 400; c++) begin
      ReqValid  = ($urandom_range(0, 3) != 0);
      RespReady = ($urandom_range(0, 3) != 0);
      set_cmd(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom(),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 4) == 0) ReqReadRegister1 = ReqWriteRegister;
      #1;
      exp_ready = !exp_valid || RespReady;
      chk("rnd.ready", {31'd0, ReqReady}, {31'd0, exp_ready});
      if (ReqValid && exp_ready) begin
        model_apply(ReqWrite, ReqWriteRegister, ReqWriteData, ReqReadRegister1, ReqReadRegister2,
                    exp_d1, exp_d2);
        exp_valid = 1'b1;
      end else if (exp_valid && RespReady) begin
        exp_valid = 1'b0;
      end
      step();
      chk("rnd.valid", {31'd0, RespValid}, {31'd0, exp_valid});
      if (exp_valid) begin
        chk("rnd.rd1", RespReadData1, exp_d1);
        chk("rnd.rd2", RespReadData2, exp_d2);
      end
      chk("rnd.wcount", {16'd0, WriteCount}, model_wc);
    end

    // Reset with a response pending: response dropped, array re-cleared.
    ReqValid = 1'b1; RespReady = 1'b0;
    set_cmd(1'b1, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd3);
    step();
    ReqValid = 1'b0;
    chk("mid.pending", {31'd0, RespValid}, 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    model_reset();
    chk("mid.valid_dropped", {31'd0, RespValid}, 32'd0);
    chk("mid.wcount", {16'd0, WriteCount}, 32'd0);
    chk("mid.ready", {31'd0, ReqReady}, 32'd0);
    RespReady = 1'b1;
    wait_clear("mid");
    do_cmd("mid.r3", 1'b0, 5'd0, 32'd0, 5'd3, 5'd5, 32'd0, 32'd0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
